// File: rtl/ex_div_pkg.sv
// ----------------------------------------------------------------------------
// ex_div_pkg
//   Shared constants and types for the EX-stage divider.
//   - div_state_e      : divider FSM encoding (FREE / BYZERO / ON / END)
//   - DIV_RESULT_*     : ready_o levels
//   - DIV_START/STOP   : EX-side request levels driven on start_i
//   - DOUBLE_REG_W     : width of the {HI, LO} result bus
// ----------------------------------------------------------------------------
package ex_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    localparam int DOUBLE_REG_W = 64;

endpackage : ex_div_pkg

// File: rtl/ex_div_if.sv
// ----------------------------------------------------------------------------
// ex_div_if
//   Request/response bundle between the EX stage (master) and the divider
//   (slave).
//   master drives : signed_div_i, opdata1_i, opdata2_i, start_i, annul_i
//   slave drives  : result_o {remainder, quotient}, ready_o
// ----------------------------------------------------------------------------
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface : ex_div_if

// File: rtl/ex_div.sv
// ----------------------------------------------------------------------------
// ex_div
//   Multi-cycle radix-2 restoring divider for the EX stage (DIV / DIVU).
//   A request is accepted in FREE; DATA_W iterations follow, then one
//   finalize cycle applies the signs, so ready_o rises DATA_W+1 edges after
//   the accepting edge. A zero divisor short-cuts to a zero result after one
//   extra edge. The result is held while start_i stays high.
//
//   Ports
//     clk      : clock, rising edge
//     rst      : synchronous, active-high reset
//     div_bus  : ex_div_if.slave (operands, start/annul in; result/ready out)
// ----------------------------------------------------------------------------
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = DOUBLE_REG_W / 2
) (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   div_bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quot_q, quot_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  divisor_zero;
    logic [DATA_W-1:0]     op1_abs, op2_abs;
    logic [DATA_W:0]       rem_shift, trial;
    logic [DATA_W-1:0]     quot_fix, rem_fix;

    // ------------------------------------------------------------------
    // Combinational helpers: acceptance, absolute values, trial subtract,
    // final sign fix-up.
    // ------------------------------------------------------------------
    assign accept       = (div_bus.start_i == DIV_START) && !div_bus.annul_i;
    assign divisor_zero = (div_bus.opdata2_i == '0);

    // MIN negates to itself; read as unsigned it is the correct magnitude.
    assign op1_abs = (div_bus.signed_div_i && div_bus.opdata1_i[DATA_W-1])
                   ? -div_bus.opdata1_i : div_bus.opdata1_i;
    assign op2_abs = (div_bus.signed_div_i && div_bus.opdata2_i[DATA_W-1])
                   ? -div_bus.opdata2_i : div_bus.opdata2_i;

    // Partial remainder is always < divisor, so the shifted value fits in
    // DATA_W+1 bits and trial[DATA_W] is the sign of (rem_shift - divisor).
    assign rem_shift = {rem_q, quot_q[DATA_W-1]};
    assign trial     = rem_shift - {1'b0, divisor_q};

    assign quot_fix = neg_quot_q ? -quot_q : quot_q;
    assign rem_fix  = neg_rem_q  ? -rem_q  : rem_q;

    // ------------------------------------------------------------------
    // State register and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // NOTE: the working registers are left without reset; they are always
    // loaded on acceptance before anything reads them.
    always_ff @(posedge clk) begin
        rem_q      <= rem_d;
        quot_q     <= quot_d;
        divisor_q  <= divisor_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_FREE: begin
                if (accept) state_d = divisor_zero ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: begin
                state_d = div_bus.annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (div_bus.annul_i)                  state_d = DIV_FREE;
                else if (cnt_q == CNT_W'(DATA_W))     state_d = DIV_END;
            end
            DIV_END: begin
                if (div_bus.start_i == DIV_STOP)      state_d = DIV_FREE;
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output next-values.
    // NOTE: every signal gets a hold default first so no path through the
    // case leaves one unassigned (which would infer a latch).
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (accept && !divisor_zero) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    quot_d     = op1_abs;
                    divisor_d  = op2_abs;
                    neg_quot_d = div_bus.signed_div_i &&
                                 (div_bus.opdata1_i[DATA_W-1] ^ div_bus.opdata2_i[DATA_W-1]);
                    neg_rem_d  = div_bus.signed_div_i && div_bus.opdata1_i[DATA_W-1];
                end
            end
            DIV_BYZERO: begin
                if (!div_bus.annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (!div_bus.annul_i) begin
                    if (cnt_q != CNT_W'(DATA_W)) begin
                        if (!trial[DATA_W]) begin
                            rem_d  = trial[DATA_W-1:0];
                            quot_d = {quot_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_d  = rem_shift[DATA_W-1:0];
                            quot_d = {quot_q[DATA_W-2:0], 1'b0};
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (div_bus.start_i == DIV_STOP) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    assign div_bus.result_o = result_q;
    assign div_bus.ready_o  = ready_q;

endmodule : ex_div
